// File: rtl/tb_uart_pkg.sv
// Shared types and constants for the port-mapped UART transmitter.
// Status bit positions and default PORT_ID values live here so firmware-facing decode stays in one place.
package tb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 8;

  localparam logic [15:0] DEF_TX_PORT     = 16'h0002;
  localparam logic [15:0] DEF_STATUS_PORT = 16'h0003;

  // Rounded clock-per-bit divisor; the transmitter needs a result of at least 2.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/tb_uart_tx_if.sv
// TramelBlaze I/O bus plus serial outputs of the UART transmitter.
// The processor/bench side is the master; the UART is the slave.
interface tb_uart_tx_if;
  logic [15:0] port_id;
  logic [15:0] out_port;
  logic        write_strobe;
  logic        read_strobe;
  logic [15:0] status;
  logic        tx;
  logic        tx_done;

  modport master (
    output port_id, out_port, write_strobe, read_strobe,
    input  status, tx, tx_done
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe,
    output status, tx, tx_done
  );
endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO: dout shows the head whenever not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/tb_uart_tx.sv
// Port-mapped 8-N-1 UART transmitter: address decode, sticky overflow, baud counter,
// frame FSM and shift register, fed by a small FWFT FIFO.
module tb_uart_tx
  import tb_uart_pkg::*;
#(
  parameter int          CLK_HZ      = 100_000_000,
  parameter int          BAUD        = 115200,
  parameter logic [15:0] TX_PORT     = DEF_TX_PORT,
  parameter logic [15:0] STATUS_PORT = DEF_STATUS_PORT,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic         clk,
  input  logic         reset,
  tb_uart_tx_if.slave  bus
);
  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 2);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2:0]     bit_idx_reg;
  logic [7:0]     shift_reg;
  logic           tx_reg;
  logic           tx_done_reg;
  logic           ovf_reg;

  logic           wr_tx;
  logic           wr_clr;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_dout;
  logic [FCW-1:0] fifo_count;
  logic           ovf_set;
  logic           unused_bits;

  assign wr_tx   = bus.write_strobe && (bus.port_id == TX_PORT);
  assign wr_clr  = bus.write_strobe && (bus.port_id == STATUS_PORT) && bus.out_port[0];
  // Pops happen only on the IDLE exit and on the final STOP cycle (gapless back-to-back frames).
  assign fifo_pop = !fifo_empty &&
                    ((state_reg == IDLE) || ((state_reg == STOP) && (cnt_reg == LAST)));
  assign ovf_set = wr_tx && fifo_full && !fifo_pop;
  assign unused_bits = ^{bus.read_strobe, bus.out_port[15:8]};

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .pop   (fifo_pop),
    .din   (bus.out_port[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_reg <= 1'b0;
    end else if (ovf_set) begin
      ovf_reg <= 1'b1;
    end else if (wr_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  // Status is built only from registers, so it never has a path from the bus inputs.
  always_comb begin
    bus.status                             = '0;
    bus.status[STAT_FULL]                  = fifo_full;
    bus.status[STAT_EMPTY]                 = fifo_empty;
    bus.status[STAT_BUSY]                  = (state_reg != IDLE);
    bus.status[STAT_OVF]                   = ovf_reg;
    bus.status[STAT_CNT_MSB:STAT_CNT_LSB]  = 5'(fifo_count);
  end

  assign bus.tx      = tx_reg;
  assign bus.tx_done = tx_done_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      tx_done_reg <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          tx_reg  <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_dout;
            state_reg <= START;
            tx_reg    <= 1'b0;
          end
        end
        START: begin
          if (cnt_reg == LAST) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DATA: begin
          if (cnt_reg == LAST) begin
            cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        STOP: begin
          // Registered pulse lands on the final stop-bit cycle.
          tx_done_reg <= (cnt_reg == PRE_LAST);
          if (cnt_reg == LAST) begin
            cnt_reg <= '0;
            if (!fifo_empty) begin
              shift_reg <= fifo_dout;
              state_reg <= START;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/tb_uart_tx.md
# tb_uart_tx

Port-mapped UART transmitter on the TramelBlaze I/O bus, a peer of the output-port comparator and load register. Firmware writes bytes to a TX port address; the block queues them in a small FIFO and serialises them 8-N-1 on a single `tx` pin. A status port returns FIFO and busy state, and a one-cycle `tx_done` pulse per frame can feed the interrupt set/reset flop.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 115200: line rate. Divisor `DIV = (CLK_HZ + BAUD/2) / BAUD`, which is 868 at the defaults.
- `TX_PORT`, 16'h0002: PORT_ID for a data write.
- `STATUS_PORT`, 16'h0003: PORT_ID for a status read or a write-to-clear.
- `FIFO_DEPTH`, 8: number of entries. Must be a power of 2, from 2 to 16.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `port_id` in 16: TramelBlaze PORT_ID.
- `out_port` in 16: TramelBlaze OUT_PORT. Only bits [7:0] are used for data.
- `write_strobe` in 1: one-cycle write qualifier.
- `read_strobe` in 1: one-cycle read qualifier.
- `status` out 16: registered status word, valid at all times.
- `tx` out 1: serial line, idle high.
- `tx_done` out 1: one-cycle pulse at the end of each stop bit.

## Operation
- **Push:** when `write_strobe` is high and `port_id==TX_PORT`, `out_port[7:0]` is enqueued.
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set.
  - If a push and a pop occur in the same cycle while full, the push is accepted and the count stays unchanged.
- **Clear overflow:** when `write_strobe` is high and `port_id==STATUS_PORT` with `out_port[0]=1`, `ovf` clears. If an overflow and a clear occur in the same cycle, set wins.
- **Status word:** `status[0]` full, `[1]` empty, `[2]` busy (FSM not in IDLE), `[3]` ovf, `[8:4]` count (0..FIFO_DEPTH), `[15:9]` 0. `read_strobe` has no side effects.
- **FSM:** IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START. Otherwise hold `tx=1`.
  - START: `tx=0` for DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx=shift[0]` for DIV cycles per bit, LSB first. After bit 7, go to STOP.
  - STOP: `tx=1` for DIV cycles. On the last cycle, pulse `tx_done`. If the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise return to IDLE.
- **Baud counter:** counts 0..DIV-1, reloads at each bit boundary, and is held at 0 in IDLE. Its width is `$clog2(DIV)`.
- **Reset (async, mid-frame allowed):**
  - FSM goes to IDLE and `tx=1` immediately. Any partial frame is abandoned.
  - FIFO is emptied, and count, `ovf` and `tx_done` are set to 0.
  - `status` resets to 16'h0002 (empty=1).

## Timing
- `tx`, `tx_done` and `status` are all registered; none are combinational from the inputs.
- With the FIFO empty and the FSM idle, a write strobe in cycle N causes:
  - count to update in N+1;
  - the pop and the IDLE→START transition in N+2;
  - `tx` to fall in N+2 (registered output follows the state).
- Each bit lasts exactly DIV cycles, so a frame is 10·DIV cycles. Back-to-back frames have no extra cycles between the stop and start bits.
- `status` reflects a push or pop one cycle after the event.
- `tx_done` is high for exactly one cycle per frame, coincident with the last STOP cycle.

## Structure
- **Shared package `tb_uart_pkg`:**
  - state enum (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - status bit-position constants;
  - default port addresses.
- **Sub-module `uart_fifo`:** synchronous FIFO with depth parameter, push/pop/din/dout/full/empty/count. It is first-word-fall-through, so `dout` is valid whenever not empty.
- **Top level:** address decode, ovf flag, baud counter, FSM and shift register.

## Test plan
- Reset mid-frame (assert during DATA bit 3) → `tx=1` immediately. After release, `status=16'h0002` and no `tx_done` occurs.
- Single write of 8'hA5 to 16'h0002 (use DIV=4 for sim) → `tx` falls 2 cycles after the strobe. Line sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles. `tx_done` pulses once at cycle 40 of the frame.
- Three back-to-back writes (8'h00, 8'hFF, 8'h55) → three contiguous 40-cycle frames with no idle gap and three `tx_done` pulses.
- Nine writes while the FSM is blocked in frame 1 (DEPTH 8): count reaches 8, so `status[0]=1`.
  - One extra write → dropped and `status[3]=1`.
  - Then write 16'h0001 to 16'h0003 → `status[3]=0`.
- Write to TX_PORT in the same cycle as a STOP-to-START pop with the FIFO full → byte accepted, count unchanged, no ovf.
- Writes to an unrelated port (16'h0005) and a `read_strobe` on STATUS_PORT → no FIFO change and no status side effects.
